// File: rtl/systolic_result_collector.sv
// rtl/systolic_result_collector.sv - launches a systolic batch, captures per-unit results, drains them in index order
module systolic_result_collector #(
   parameter int WIDTH          = 16,
   parameter int NUM_UNITS      = 64,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int IW            = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       launch,
   input  logic [NUM_UNITS-1:0]       active_units,
   output logic                       start,
   input  logic [NUM_UNITS-1:0]       done_array,
   input  logic [NUM_UNITS*WIDTH-1:0] result_array,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [IW-1:0]              out_index,
   output logic                       out_last,
   output logic                       busy,
   output logic                       batch_done,
   output logic                       timeout
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   logic [2:0]           state, state_d;
   logic [NUM_UNITS-1:0] mask_q, seen_q, pending_q, new_done, seen_next;
   logic [TW-1:0]        timer_q, timer_next;
   logic [WIDTH-1:0]     buffer [NUM_UNITS];
   logic [IW-1:0]        low_idx;
   logic                 pending_one;

   always_comb begin
      new_done    = mask_q & done_array & ~seen_q;
      seen_next   = seen_q | new_done;
      timer_next  = timer_q + TW'(1);
      low_idx     = '0;
      for (int i = NUM_UNITS - 1; i >= 0; i--)
         if (pending_q[i]) low_idx = IW'(i);
      pending_one = (pending_q != '0) && ((pending_q & (pending_q - NUM_UNITS'(1))) == '0);
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:   if (launch) state_d = (active_units == '0) ? S_FINISH : S_START;
         S_START:  state_d = S_WAIT;
         S_WAIT: begin
            if (seen_next == mask_q)
               state_d = S_DRAIN;
            else if (timer_next == TW'(TIMEOUT_CYCLES - 1))
               state_d = (seen_next == '0) ? S_FINISH : S_DRAIN;
         end
         S_DRAIN:  if (out_valid && out_ready && out_last) state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Result storage carries no reset; its contents only matter for captured units.
   always_ff @(posedge clk) begin
      if (state == S_WAIT)
         for (int i = 0; i < NUM_UNITS; i++)
            if (new_done[i]) buffer[i] <= result_array[i*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         mask_q     <= '0;
         seen_q     <= '0;
         pending_q  <= '0;
         timer_q    <= '0;
         start      <= 1'b0;
         busy       <= 1'b0;
         batch_done <= 1'b0;
         timeout    <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_index  <= '0;
         out_last   <= 1'b0;
      end else begin
         state      <= state_d;
         start      <= (state_d == S_START);
         busy       <= (state_d != S_IDLE);
         batch_done <= (state == S_FINISH);
         case (state)
            S_IDLE: begin
               if (launch) begin
                  mask_q  <= active_units;
                  seen_q  <= '0;
                  timeout <= 1'b0;
               end
            end
            S_START: timer_q <= '0;
            S_WAIT: begin
               seen_q  <= seen_next;
               timer_q <= timer_next;
               if (state_d == S_DRAIN) pending_q <= seen_next;
               if ((state_d != S_WAIT) && (seen_next != mask_q)) timeout <= 1'b1;
            end
            S_DRAIN: begin
               // Load a word on DRAIN entry or on each accepted handshake; the taken bit leaves pending.
               if (!out_valid || out_ready) begin
                  if (out_valid && out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                  end else begin
                     out_valid          <= 1'b1;
                     out_index          <= low_idx;
                     out_data           <= buffer[low_idx];
                     out_last           <= pending_one;
                     pending_q[low_idx] <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_result_collector.sv
// tb/tb_systolic_result_collector.sv - table-driven scoreboard bench for systolic_result_collector
module tb_systolic_result_collector;

   localparam int W  = 16;
   localparam int NU = 16;
   localparam int T  = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          launch;
   logic [NU-1:0] active_units;
   logic          start;
   logic [NU-1:0] done_array;
   logic [NU*W-1:0] result_array;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [3:0]    out_index;
   logic          out_last;
   logic          busy;
   logic          batch_done;
   logic          timeout;

   systolic_result_collector #(.WIDTH(W), .NUM_UNITS(NU), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset_n(reset_n), .launch(launch), .active_units(active_units),
      .start(start), .done_array(done_array), .result_array(result_array),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last), .busy(busy),
      .batch_done(batch_done), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NU-1:0] mask;
      logic [NU-1:0] dones_a;
      int            da;
      logic [NU-1:0] dones_b;
      int            db;
      logic [W-1:0]  fixed;
      int            ready_mode;
      int            hold_launch;
      int            exp_bd;
      logic          exp_to;
      int            exp_n;
   } vec_t;

   typedef struct {
      logic [3:0]   idx;
      logic [W-1:0] data;
      logic         last;
   } word_t;

   vec_t  vecs[8];
   word_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int n, bd_n, starts, hs, ls, rel, total, k;
      logic [NU-1:0] seen;
      logic [W-1:0]  expb [NU];
      logic          held_v;
      logic [3:0]    h_idx;
      logic [W-1:0]  h_data;
      logic          h_last;
      word_t         e;
      exp_q.delete();
      seen = '0; starts = 0; hs = 0; bd_n = -1; held_v = 1'b0;
      ls = 1 + (((v.dones_b != '0) && (v.db > v.da)) ? v.db : v.da);
      @(negedge clk);
      launch = 1'b1; active_units = v.mask; done_array = '0;
      out_ready = (v.ready_mode == 0);
      for (n = 1; n <= 200 && bd_n < 0; n++) begin
         @(negedge clk);
         if (start) starts++;
         if (n == 1) begin
            chk("busy_after_launch", busy, 1);
            chk("timeout_cleared", timeout, 0);
         end
         if (held_v) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_index", out_index, h_idx);
            chk("stall_data", out_data, h_data);
            chk("stall_last", out_last, h_last);
         end
         if (v.exp_to && n == T)     chk("timeout_early", timeout, 0);
         if (v.exp_to && n == T + 1) chk("timeout_set", timeout, 1);
         if (batch_done) bd_n = n;
         launch = (v.hold_launch != 0) && (bd_n < 0);
         done_array = '0;
         if (n == 1 + v.da) done_array |= v.dones_a;
         if ((v.dones_b != '0) && n == 1 + v.db) done_array |= v.dones_b;
         for (int i = 0; i < NU; i++) begin
            result_array[i*W +: W] = (v.fixed != '0) ? v.fixed : W'($urandom);
            if (done_array[i] && v.mask[i] && !seen[i]) begin
               seen[i] = 1'b1;
               expb[i] = result_array[i*W +: W];
            end
         end
         if (n == ls) begin
            total = $countones(seen);
            k = 0;
            for (int i = 0; i < NU; i++)
               if (seen[i]) begin
                  k++;
                  e.idx = 4'(i); e.data = expb[i]; e.last = (k == total);
                  exp_q.push_back(e);
               end
         end
         if (v.ready_mode == 1) begin
            rel = n - (2 + v.da);
            out_ready = (rel < 5) ? 1'b0 : ((rel % 2) == 1);
         end
         held_v = out_valid && !out_ready;
         h_idx = out_index; h_data = out_data; h_last = out_last;
         if (out_valid && out_ready) begin
            hs++;
            if (exp_q.size() == 0) begin
               chk("unexpected_word", out_index, 4'hF);
               chk("unexpected_word_valid", out_valid, 0);
            end else begin
               e = exp_q.pop_front();
               chk("word_index", out_index, e.idx);
               chk("word_data", out_data, e.data);
               chk("word_last", out_last, e.last);
            end
         end
      end
      launch = 1'b0; done_array = '0;
      chk("batch_done_seen", (bd_n >= 0), 1);
      if (v.exp_bd >= 0) chk("batch_done_cycle", bd_n, v.exp_bd);
      chk("start_count", starts, (v.mask != '0));
      chk("word_count", hs, v.exp_n);
      chk("queue_empty", exp_q.size(), 0);
      chk("timeout_sticky", timeout, v.exp_to);
      @(negedge clk);
      chk("batch_done_single", batch_done, 0);
      chk("idle_busy", busy, 0);
      out_ready = 1'b1;
   endtask

   initial begin
      int cnt;
      //          mask      dones_a  da dones_b  db fixed    rdy hold bd  to   n
      vecs[0] = '{16'h000F, 16'h000F, 5, 16'h0000, 0, 16'h4600, 0, 0, 13, 1'b0, 4};
      vecs[1] = '{16'h0005, 16'h0006, 3, 16'h0005, 7, 16'h0000, 0, 0, 13, 1'b0, 2};
      vecs[2] = '{16'h0003, 16'h0003, 2, 16'h0000, 0, 16'h0000, 1, 0, -1, 1'b0, 2};
      vecs[3] = '{16'h0007, 16'h0002, 4, 16'h0000, 0, 16'h0000, 0, 0, 20, 1'b1, 1};
      vecs[4] = '{16'h0000, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0, 0, 2,  1'b0, 0};
      vecs[5] = '{16'h0010, 16'h0020, 2, 16'h0000, 0, 16'h0000, 0, 0, 18, 1'b1, 0};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1, 16'h0000, 0, 16'h0000, 0, 0, 21, 1'b0, 16};
      vecs[7] = '{16'h8001, 16'h8001, 2, 16'h0000, 0, 16'h0000, 0, 1, 8,  1'b0, 2};

      reset_n = 1'b0; launch = 1'b0; active_units = '0; done_array = '0;
      result_array = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_start", start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_batch_done", batch_done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_data", out_data, 0);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Asynchronous reset in the middle of a stalled drain.
      @(negedge clk);
      active_units = 16'h0003; launch = 1'b1; out_ready = 1'b0;
      @(negedge clk); launch = 1'b0;
      @(negedge clk); done_array = 16'h0003;
      @(negedge clk); done_array = '0;
      cnt = 0;
      while (!out_valid && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      chk("rst_pre_valid", out_valid, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("async_valid", out_valid, 0);
      chk("async_busy", busy, 0);
      chk("async_start", start, 0);
      chk("async_index", out_index, 0);
      @(negedge clk);
      reset_n = 1'b1; out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_valid", out_valid, 0);
         chk("post_rst_batch_done", batch_done, 0);
         chk("post_rst_busy", busy, 0);
      end
      run_vec(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
